// File: rtl/uart_cmd_parser_pkg.sv
// Shared ASCII constants and FSM state encodings for the UART command parser.
package uart_cmd_parser_pkg;

  localparam logic [7:0] ChW  = 8'h57;
  localparam logic [7:0] ChR  = 8'h52;
  localparam logic [7:0] ChK  = 8'h4B;
  localparam logic [7:0] ChE  = 8'h45;
  localparam logic [7:0] ChCr = 8'h0D;
  localparam logic [7:0] ChLf = 8'h0A;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StAddr   = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StEol    = 3'd3;
  localparam logic [2:0] StSkip   = 3'd4;
  localparam logic [2:0] StExec   = 3'd5;
  localparam logic [2:0] StRdwait = 3'd6;
  localparam logic [2:0] StResp   = 3'd7;

  // Receive states are encoded below the busy states so one compare suffices.
  function automatic logic is_rx_state(input logic [2:0] st);
    return (st <= StSkip);
  endfunction

endpackage

// File: rtl/hex_ascii.sv
// Combinational hex helper: Encode=0 maps ASCII to {4'h0, nibble} with valid_o = is-hex,
// Encode=1 maps in_i[3:0] to an uppercase ASCII digit with valid_o = upper nibble clear.
module hex_ascii #(
  parameter bit Encode = 1'b0
) (
  input  logic [7:0] in_i,
  output logic [7:0] out_o,
  output logic       valid_o
);

  always_comb begin
    out_o   = 8'h00;
    valid_o = 1'b0;
    if (Encode) begin
      valid_o = (in_i[7:4] == 4'h0);
      out_o   = (in_i[3:0] < 4'd10) ? (8'h30 + {4'h0, in_i[3:0]})
                                    : (8'h37 + {4'h0, in_i[3:0]});
    end else if (in_i >= 8'h30 && in_i <= 8'h39) begin
      valid_o = 1'b1;
      out_o   = in_i - 8'h30;
    end else if (in_i >= 8'h41 && in_i <= 8'h46) begin
      valid_o = 1'b1;
      out_o   = in_i - 8'h37;
    end else if (in_i >= 8'h61 && in_i <= 8'h66) begin
      valid_o = 1'b1;
      out_o   = in_i - 8'h57;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII "W<addr><data>\n" / "R<addr>\n" parser driving a simple register bus with
// K/E/hex responses. Optional byte echo enabled by defining UART_CMD_PARSER_ECHO_EN.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              err_drop
);

  localparam int unsigned AddrDigits = ADDR_W / 4;
  localparam int unsigned DataDigits = DATA_W / 4;
  localparam int unsigned RespLen    = DataDigits + 1;
  localparam int unsigned MaxDigits  = (AddrDigits > DataDigits) ? AddrDigits : DataDigits;
  localparam int unsigned CntW       = $clog2(MaxDigits + 1);
  localparam int unsigned LenW       = $clog2(RespLen + 1);

  logic [2:0]                  state_q, state_d;
  logic                        op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [DATA_W-1:0]           wdata_q, wdata_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [RespLen-1:0][7:0]     resp_q, resp_d;
  logic [RespLen-1:0]          resp_hex_q, resp_hex_d;
  logic [LenW-1:0]             resp_len_q, resp_len_d;

  logic [7:0] dec_out, enc_out, resp_byte;
  logic       dec_hex, enc_valid;
  logic       rx_take, echo_block, resp_active, resp_adv;
  logic       syn_err, load_e, load_k;
  logic       is_cr, is_lf;

  hex_ascii #(.Encode(1'b0)) u_dec (
    .in_i    (rx_data),
    .out_o   (dec_out),
    .valid_o (dec_hex)
  );

  // Read data is kept as raw nibbles and converted to ASCII on the way out.
  hex_ascii #(.Encode(1'b1)) u_enc (
    .in_i    (resp_q[0]),
    .out_o   (enc_out),
    .valid_o (enc_valid)
  );

  assign is_cr       = (rx_data == ChCr);
  assign is_lf       = (rx_data == ChLf);
  assign resp_active = (state_q == StResp);
  assign resp_byte   = (resp_hex_q[0] && enc_valid) ? enc_out : resp_q[0];
  assign rx_take     = rx_valid && is_rx_state(state_q) && !echo_block;
  assign err_drop    = rx_valid && !rx_take;

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = (state_q == StExec) && op_wr_q;
  assign reg_re    = (state_q == StExec) && !op_wr_q;

  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    resp_hex_d = resp_hex_q;
    resp_len_d = resp_len_q;
    syn_err    = 1'b0;
    load_e     = 1'b0;
    load_k     = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_take && !is_cr) begin
          if (rx_data == ChW || rx_data == ChR) begin
            op_wr_d = (rx_data == ChW);
            addr_d  = '0;
            cnt_d   = '0;
            state_d = StAddr;
          end else if (!is_lf) begin
            state_d = StSkip;
          end
        end
      end
      StAddr: begin
        if (rx_take && !is_cr) begin
          if (dec_hex) begin
            addr_d = (addr_q << 4) | ADDR_W'(dec_out);
            if (cnt_q == CntW'(AddrDigits - 1)) begin
              cnt_d   = '0;
              state_d = op_wr_q ? StData : StEol;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            syn_err = 1'b1;
          end
        end
      end
      StData: begin
        if (rx_take && !is_cr) begin
          if (dec_hex) begin
            wdata_d = (wdata_q << 4) | DATA_W'(dec_out);
            if (cnt_q == CntW'(DataDigits - 1)) begin
              cnt_d   = '0;
              state_d = StEol;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            syn_err = 1'b1;
          end
        end
      end
      StEol: begin
        if (rx_take && !is_cr) begin
          if (is_lf) state_d = StExec;
          else       syn_err = 1'b1;
        end
      end
      StSkip: begin
        if (rx_take && is_lf) load_e = 1'b1;
      end
      StExec: begin
        if (op_wr_q) load_k = 1'b1;
        else         state_d = StRdwait;
      end
      StRdwait: begin
        resp_d     = '0;
        resp_hex_d = '0;
        for (int i = 0; i < int'(DataDigits); i++) begin
          resp_d[i]     = {4'h0, reg_rdata[DATA_W-1-4*i -: 4]};
          resp_hex_d[i] = 1'b1;
        end
        resp_d[DataDigits] = ChLf;
        resp_len_d         = LenW'(RespLen);
        state_d            = StResp;
      end
      StResp: begin
        if (resp_adv) begin
          resp_d     = resp_q >> 8;
          resp_hex_d = resp_hex_q >> 1;
          resp_len_d = resp_len_q - 1'b1;
          if (resp_len_q == LenW'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A malformed line answers at once on LF, otherwise waits for the LF in SKIP.
    if (syn_err) begin
      if (is_lf) load_e = 1'b1;
      else       state_d = StSkip;
    end

    if (load_e || load_k) begin
      resp_d     = '0;
      resp_hex_d = '0;
      resp_d[0]  = load_k ? ChK : ChE;
      resp_d[1]  = ChLf;
      resp_len_d = LenW'(2);
      state_d    = StResp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      resp_q     <= '0;
      resp_hex_q <= '0;
      resp_len_q <= '0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      resp_hex_q <= resp_hex_d;
      resp_len_q <= resp_len_d;
    end
  end

`ifdef UART_CMD_PARSER_ECHO_EN
  logic       echo_valid_q;
  logic [7:0] echo_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_valid_q <= 1'b0;
      echo_data_q  <= 8'h00;
    end else if (rx_take) begin
      echo_valid_q <= 1'b1;
      echo_data_q  <= rx_data;
    end else if (echo_valid_q && tx_ready) begin
      echo_valid_q <= 1'b0;
    end
  end

  // A buffer draining this cycle can take the next byte.
  assign echo_block = echo_valid_q && !tx_ready;
  assign tx_valid   = echo_valid_q || resp_active;
  assign tx_data    = echo_valid_q ? echo_data_q : (resp_active ? resp_byte : 8'h00);
  assign resp_adv   = resp_active && tx_ready && !echo_valid_q;
`else
  assign echo_block = 1'b0;
  assign tx_valid   = resp_active;
  assign tx_data    = resp_active ? resp_byte : 8'h00;
  assign resp_adv   = resp_active && tx_ready;
`endif

endmodule
